rv32_csr_initiator: RTL and testbench

Command-driven initiator for the CSR access port. It turns debug/host CSR commands (address, write op, value) into a single atomic read-modify-write slot on the CSR file's port, then returns the old CSR value. Sits between the debug transport and the CSR file. Arbitrates with the pipeline through a request/grant pair, so the pipeline's own CSR accesses are never corrupted.

---
 rtl/rv32_csr_pkg.sv | 26 ++
 rtl/rv32_csr_initiator.sv | 138 +++++++++++++
 tb/tb_rv32_csr_initiator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_csr_pkg.sv
// Shared encodings for the CSR access port: write ops, operand select,
// initiator FSM states and the read-only address predicate.
package rv32_csr_pkg;

  typedef enum logic [1:0] {
    OP_RW  = 2'b00,
    OP_RS  = 2'b01,
    OP_RC  = 2'b10,
    OP_ILL = 2'b11
  } csr_op_e;

  localparam logic SRC_IMM = 1'b0;
  localparam logic SRC_REG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_e;

  // CSRs with address bits [11:10] == 2'b11 are read-only
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/rv32_csr_initiator.sv
// Debug/host CSR command initiator: one atomic read-modify-write slot per
// command on the shared CSR port, arbitrated with the pipeline via req/gnt.
module rv32_csr_initiator
  import rv32_csr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMER_WIDTH    = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [11:0] cmd_csr_in,
  input  logic [1:0]  cmd_write_op_in,
  input  logic        cmd_write_in,
  input  logic [31:0] cmd_value_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rsp_value_out,
  output logic        rsp_error_out,
  output logic        csr_req_out,
  input  logic        csr_gnt_in,
  input  logic [31:0] csr_read_value_in,
  output logic        csr_read_out,
  output logic        csr_write_out,
  output logic [1:0]  csr_write_op_out,
  output logic        csr_src_out,
  output logic [11:0] csr_out,
  output logic [31:0] csr_rs1_value_out,
  output logic [31:0] csr_imm_value_out
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                 state_reg, state_next;
  logic [TIMER_WIDTH-1:0] timer_reg, timer_next;
  logic [11:0]            csr_reg, csr_next;
  csr_op_e                op_reg, op_next;
  logic                   write_reg, write_next;
  logic [31:0]            value_reg, value_next;
  logic [31:0]            rsp_value_reg, rsp_value_next;
  logic                   rsp_error_reg, rsp_error_next;
  logic                   write_effective;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      csr_reg       <= '0;
      op_reg        <= OP_RW;
      write_reg     <= 1'b0;
      value_reg     <= '0;
      rsp_value_reg <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      csr_reg       <= csr_next;
      op_reg        <= op_next;
      write_reg     <= write_next;
      value_reg     <= value_next;
      rsp_value_reg <= rsp_value_next;
      rsp_error_reg <= rsp_error_next;
    end
  end

  // Set/clear with a zero operand has no side effect, so it must not strobe a write
  assign write_effective = write_reg &&
                           ((op_reg == OP_RW) ||
                            (((op_reg == OP_RS) || (op_reg == OP_RC)) && (value_reg != '0)));

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    csr_next       = csr_reg;
    op_next        = op_reg;
    write_next     = write_reg;
    value_next     = value_reg;
    rsp_value_next = rsp_value_reg;
    rsp_error_next = rsp_error_reg;
    cmd_ready_out  = 1'b0;
    csr_req_out    = 1'b0;
    csr_read_out   = 1'b0;
    csr_write_out  = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in) begin
          csr_next       = cmd_csr_in;
          op_next        = csr_op_e'(cmd_write_op_in);
          write_next     = cmd_write_in;
          value_next     = cmd_value_in;
          timer_next     = '0;
          rsp_value_next = '0;
          if (cmd_write_in && ((cmd_write_op_in == OP_ILL) || csr_is_read_only(cmd_csr_in))) begin
            rsp_error_next = 1'b1;
            state_next     = RESP;
          end else begin
            rsp_error_next = 1'b0;
            state_next     = REQ;
          end
        end
      end
      REQ: begin
        csr_req_out = 1'b1;
        // A grant on the final timer cycle takes priority over the timeout
        if (csr_gnt_in) begin
          csr_read_out   = 1'b1;
          csr_write_out  = write_effective;
          rsp_value_next = csr_read_value_in;
          rsp_error_next = 1'b0;
          state_next     = RESP;
        end else if (timer_reg == TIMER_LAST) begin
          rsp_value_next = '0;
          rsp_error_next = 1'b1;
          state_next     = RESP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid_out     = (state_reg == RESP);
  assign rsp_value_out     = rsp_value_reg;
  assign rsp_error_out     = rsp_error_reg;
  assign csr_out           = csr_reg;
  assign csr_write_op_out  = op_reg;
  assign csr_rs1_value_out = value_reg;
  assign csr_src_out       = SRC_REG;
  assign csr_imm_value_out = '0;

endmodule

// File: tb/tb_rv32_csr_initiator.sv
// Directed table-driven bench for rv32_csr_initiator with a one-register
// CSR file model (mscratch at 0x340), plus reset and backpressure sequences.
module tb_rv32_csr_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [11:0] cmd_csr_in;
  logic [1:0]  cmd_write_op_in;
  logic        cmd_write_in;
  logic [31:0] cmd_value_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [31:0] rsp_value_out;
  logic        rsp_error_out;
  logic        csr_req_out;
  logic        csr_gnt_in;
  logic [31:0] csr_read_value_in;
  logic        csr_read_out;
  logic        csr_write_out;
  logic [1:0]  csr_write_op_out;
  logic        csr_src_out;
  logic [11:0] csr_out;
  logic [31:0] csr_rs1_value_out;
  logic [31:0] csr_imm_value_out;

  logic [31:0] mscratch;
  int          vec_count = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign csr_read_value_in = (csr_out == 12'h340) ? mscratch : {20'h0, csr_out};

  rv32_csr_initiator #(.TIMEOUT_CYCLES(4), .TIMER_WIDTH(3)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd_valid_in      (cmd_valid_in),
    .cmd_ready_out     (cmd_ready_out),
    .cmd_csr_in        (cmd_csr_in),
    .cmd_write_op_in   (cmd_write_op_in),
    .cmd_write_in      (cmd_write_in),
    .cmd_value_in      (cmd_value_in),
    .rsp_valid_out     (rsp_valid_out),
    .rsp_ready_in      (rsp_ready_in),
    .rsp_value_out     (rsp_value_out),
    .rsp_error_out     (rsp_error_out),
    .csr_req_out       (csr_req_out),
    .csr_gnt_in        (csr_gnt_in),
    .csr_read_value_in (csr_read_value_in),
    .csr_read_out      (csr_read_out),
    .csr_write_out     (csr_write_out),
    .csr_write_op_out  (csr_write_op_out),
    .csr_src_out       (csr_src_out),
    .csr_out           (csr_out),
    .csr_rs1_value_out (csr_rs1_value_out),
    .csr_imm_value_out (csr_imm_value_out)
  );

  typedef struct {
    logic [11:0] csr;
    logic [1:0]  op;
    logic        wr;
    logic [31:0] val;
    int          gdel;     // REQ cycles before grant rises (then held high)
    int          bp;       // extra cycles rsp_ready_in is held low
    logic [31:0] exp_val;
    logic        exp_err;
    int          exp_rd;
    int          exp_wr;
    int          exp_req;
    int          exp_lat;  // cycles from accept edge to rsp_valid_out
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          cyc, rd_cnt, wr_cnt, req_cnt;
    logic        pend;
    logic [1:0]  pop;
    logic [31:0] pval;
    logic [11:0] paddr;
    logic [31:0] held_val;
    logic        held_err;
    rd_cnt = 0; wr_cnt = 0; req_cnt = 0;
    @(negedge clk);
    cmd_valid_in = 1'b1; cmd_csr_in = v.csr; cmd_write_op_in = v.op;
    cmd_write_in = v.wr; cmd_value_in = v.val;
    #1 chk("cmd_ready", {31'h0, cmd_ready_out}, 32'h1);
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;
    cyc = 1;
    while (1) begin
      csr_gnt_in = (cyc - 1 >= v.gdel);
      #1;
      if (rsp_valid_out) break;
      if (cyc > 20) begin
        miscompares++;
        $display("FAIL rsp_wait vec %0d: no response within 20 cycles", idx);
        break;
      end
      pend = 1'b0; pop = 2'b00; pval = '0; paddr = '0;
      if (csr_req_out) req_cnt++;
      if (csr_read_out) begin
        rd_cnt++;
        chk("grant_addr", {20'h0, csr_out}, {20'h0, v.csr});
        chk("grant_op", {30'h0, csr_write_op_out}, {30'h0, v.op});
        chk("grant_rs1", csr_rs1_value_out, v.val);
        chk("grant_src_imm", {csr_src_out, csr_imm_value_out[30:0]}, 32'h8000_0000);
      end
      if (csr_write_out) begin
        wr_cnt++;
        pend = 1'b1; pop = csr_write_op_out; pval = csr_rs1_value_out; paddr = csr_out;
      end
      @(posedge clk);
      #1;
      if (pend && paddr == 12'h340) begin
        case (pop)
          2'b00:   mscratch = pval;
          2'b01:   mscratch = mscratch | pval;
          2'b10:   mscratch = mscratch & ~pval;
          default: mscratch = mscratch;
        endcase
      end
      cyc++;
    end
    chk("rsp_latency", cyc, v.exp_lat);
    chk("rsp_value", rsp_value_out, v.exp_val);
    chk("rsp_error", {31'h0, rsp_error_out}, {31'h0, v.exp_err});
    chk("read_strobes", rd_cnt, v.exp_rd);
    chk("write_strobes", wr_cnt, v.exp_wr);
    chk("req_cycles", req_cnt, v.exp_req);
    held_val = rsp_value_out; held_err = rsp_error_out;
    for (int i = 0; i < v.bp; i++) begin
      @(posedge clk);
      #2;
      chk("bp_valid", {31'h0, rsp_valid_out}, 32'h1);
      chk("bp_value", rsp_value_out, held_val);
      chk("bp_error_ready", {30'h0, rsp_error_out, cmd_ready_out}, {30'h0, held_err, 1'b0});
    end
    rsp_ready_in = 1'b1;
    #1 chk("hs_cmd_ready", {31'h0, cmd_ready_out}, 32'h0);
    @(posedge clk);
    #1 rsp_ready_in = 1'b0; csr_gnt_in = 1'b0;
    $display("vec %0d: csr=0x%03h op=%0d wr=%0d val=0x%08h -> value=0x%08h err=%0d lat=%0d rd=%0d wr=%0d",
             idx, v.csr, v.op, v.wr, v.val, held_val, held_err, cyc, rd_cnt, wr_cnt);
  endtask

  initial begin
    int strobes;
    //          csr      op     wr    val            gdel bp exp_val        err  rd wr req lat
    vecs[0]  = '{12'h340, 2'b00, 1'b0, 32'h0,         0,  0, 32'hDEADBEEF, 1'b0, 1, 0, 1, 2};
    vecs[1]  = '{12'h340, 2'b00, 1'b1, 32'h10,        0,  0, 32'hDEADBEEF, 1'b0, 1, 1, 1, 2};
    vecs[2]  = '{12'h340, 2'b01, 1'b1, 32'hF,         1,  0, 32'h10,       1'b0, 1, 1, 2, 3};
    vecs[3]  = '{12'h340, 2'b00, 1'b0, 32'h0,         0,  5, 32'h1F,       1'b0, 1, 0, 1, 2};
    vecs[4]  = '{12'h340, 2'b10, 1'b1, 32'h0,         0,  0, 32'h1F,       1'b0, 1, 0, 1, 2};
    vecs[5]  = '{12'h340, 2'b10, 1'b1, 32'h3,         2,  0, 32'h1F,       1'b0, 1, 1, 3, 4};
    vecs[6]  = '{12'h340, 2'b01, 1'b0, 32'hFF,        0,  0, 32'h1C,       1'b0, 1, 0, 1, 2};
    vecs[7]  = '{12'h340, 2'b11, 1'b1, 32'h5,         0,  0, 32'h0,        1'b1, 0, 0, 0, 1};
    vecs[8]  = '{12'hC00, 2'b00, 1'b1, 32'h5,         0,  0, 32'h0,        1'b1, 0, 0, 0, 1};
    vecs[9]  = '{12'hC00, 2'b00, 1'b0, 32'h0,         0,  0, 32'h00000C00, 1'b0, 1, 0, 1, 2};
    vecs[10] = '{12'h305, 2'b11, 1'b0, 32'h0,         0,  0, 32'h00000305, 1'b0, 1, 0, 1, 2};
    vecs[11] = '{12'h340, 2'b00, 1'b0, 32'h0,         99, 0, 32'h0,        1'b1, 0, 0, 4, 5};
    vecs[12] = '{12'h340, 2'b01, 1'b1, 32'h20,        3,  0, 32'h1C,       1'b0, 1, 1, 4, 5};
    vecs[13] = '{12'h340, 2'b00, 1'b0, 32'h0,         0,  0, 32'h3C,       1'b0, 1, 0, 1, 2};
    vecs[14] = '{12'hC01, 2'b01, 1'b0, 32'h0,         0,  0, 32'h00000C01, 1'b0, 1, 0, 1, 2};

    mscratch = 32'hDEADBEEF;
    reset_n = 1'b0; cmd_valid_in = 1'b0; cmd_csr_in = '0; cmd_write_op_in = '0;
    cmd_write_in = 1'b0; cmd_value_in = '0; rsp_ready_in = 1'b0; csr_gnt_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready_valid_req", {29'h0, cmd_ready_out, rsp_valid_out, csr_req_out}, 32'h4);
    chk("reset_rsp", {rsp_error_out, rsp_value_out[30:0]}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset while waiting in REQ: abandon the command, no strobe, no response
    @(negedge clk);
    cmd_valid_in = 1'b1; cmd_csr_in = 12'h340; cmd_write_op_in = 2'b00;
    cmd_write_in = 1'b1; cmd_value_in = 32'h5555_AAAA;
    @(posedge clk);
    #1 cmd_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_ready_valid_req", {29'h0, cmd_ready_out, rsp_valid_out, csr_req_out}, 32'h4);
    chk("midreset_strobes", {30'h0, csr_read_out, csr_write_out}, 32'h0);
    chk("midreset_rsp", {rsp_error_out, rsp_value_out[30:0]}, 32'h0);
    csr_gnt_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      if (csr_read_out || csr_write_out || csr_req_out || rsp_valid_out) strobes++;
    end
    chk("post_reset_activity", strobes, 0);
    csr_gnt_in = 1'b0;
    $display("reset-in-REQ sequence: activity after release = %0d cycles", strobes);

    run_vec(15, vecs[13]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
